bf_stream_feeder: RTL

Byte-stream front/back end for the Blowfish cipher core. It packs an incoming 8-bit stream into 64-bit big-endian blocks and drives the core's `start`/`key`/`plaintext`/`enc`/`dec` inputs. It waits for the core's done flag, captures the 64-bit result and serialises it back out as bytes. It sits directly between the byte-oriented system interface and the `blowfish` core, one block in flight at a time.

---
 rtl/bf_pkg.sv | 13 +
 rtl/bf_byte_serializer.sv | 56 +++++
 rtl/bf_stream_feeder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared types and sizing for the Blowfish byte-stream feeder.
package bf_pkg;

    localparam int unsigned BLOCK_BYTES = 8;
    localparam int unsigned CNT_W       = $clog2(BLOCK_BYTES) + 1;

    typedef enum logic [1:0] {
        FILL,
        CIPHER,
        DRAIN
    } state_t;

endpackage

// File: rtl/bf_byte_serializer.sv
// Loads one 64-bit block and shifts it out MSB byte first over valid/ready.
module bf_byte_serializer
    import bf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic        load_last,
    input  logic        ready,
    output logic [7:0]  data,
    output logic        valid,
    output logic        last,
    output logic        done
);

    logic [63:0]      sr;
    logic [CNT_W-1:0] remaining;
    logic             last_blk_q;
    logic             fire;

    assign fire = valid & ready;
    assign data = sr[63:56];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            remaining  <= '0;
            valid      <= 1'b0;
            last       <= 1'b0;
            last_blk_q <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                sr         <= load_data;
                remaining  <= CNT_W'(BLOCK_BYTES);
                valid      <= 1'b1;
                last       <= 1'b0;
                last_blk_q <= load_last;
            end else if (fire) begin
                sr        <= {sr[55:0], 8'h00};
                remaining <= remaining - CNT_W'(1);
                // last is raised as the 7th byte leaves so it is registered alongside the 8th
                if (remaining == CNT_W'(1)) begin
                    valid <= 1'b0;
                    last  <= 1'b0;
                    done  <= 1'b1;
                end else if (remaining == CNT_W'(2)) begin
                    last <= last_blk_q;
                end
            end
        end
    end

endmodule

// File: rtl/bf_stream_feeder.sv
// Packs a byte stream into 64-bit blocks for the Blowfish core and serialises results.
module bf_stream_feeder
    import bf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        mode_dec,
    input  logic [63:0] key_in,
    output logic        core_start,
    output logic        core_enc,
    output logic        core_dec,
    output logic [63:0] core_key,
    output logic [63:0] core_text,
    input  logic        core_done,
    input  logic [63:0] core_result,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        protocol_err
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      text_q, key_q;
    logic             mode_q, first_of_msg, last_blk;
    logic             accept, blk_end, ser_load, ser_done;

    assign accept   = in_valid & in_ready;
    assign blk_end  = accept & (in_last | (cnt == CNT_W'(BLOCK_BYTES - 1)));
    assign ser_load = (state == CIPHER) & core_done;

    assign core_enc  = ~mode_q;
    assign core_dec  = mode_q;
    assign core_key  = key_q;
    assign core_text = text_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (blk_end)   state_nxt = CIPHER;
            CIPHER:  if (core_done) state_nxt = DRAIN;
            // hold in DRAIN until the core has released done, so a stale done is never misread
            DRAIN:   if (!out_valid && !core_done) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_ready = (state == FILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            text_q       <= '0;
            key_q        <= '0;
            mode_q       <= 1'b0;
            first_of_msg <= 1'b1;
            last_blk     <= 1'b0;
            core_start   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (core_done && state == FILL) protocol_err <= 1'b1;
            case (state)
                FILL: begin
                    if (accept) begin
                        for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
                            if (cnt == CNT_W'(i)) text_q[8*(BLOCK_BYTES-1-i) +: 8] <= in_data;
                        end
                        cnt          <= cnt + CNT_W'(1);
                        first_of_msg <= 1'b0;
                        if (first_of_msg) begin
                            mode_q <= mode_dec;
                            key_q  <= key_in;
                        end
                        if (blk_end) begin
                            core_start <= 1'b1;
                            last_blk   <= in_last;
                            cnt        <= '0;
                        end
                    end
                end
                CIPHER: begin
                    if (core_done) core_start <= 1'b0;
                end
                DRAIN: begin
                    if (ser_done && last_blk) first_of_msg <= 1'b1;
                    if (state_nxt == FILL) begin
                        text_q <= '0;
                        cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    bf_byte_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_data (core_result),
        .load_last (last_blk),
        .ready     (out_ready),
        .data      (out_data),
        .valid     (out_valid),
        .last      (out_last),
        .done      (ser_done)
    );

endmodule
